// File: rtl/jtag_types_pkg.sv
// -----------------------------------------------------------------------------
// jtag_types_pkg
//   Shared JTAG TAP datapath types and constants:
//     IR_LEN        - instruction register length (4)
//     OP_*          - raw IR opcodes
//     IR_CAPTURE    - value loaded into the IR shift register on capture_ir
//     instruction_t - decoded instruction enum
//     RESET_INSTR   - instruction selected by nTRST / tlr_reset
//     decode_ir()   - maps a raw IR code onto instruction_t
//
//   Build option: JTAG_IDCODE_EN
//     defined   - IDCODE opcode decodes to IDCODE, which is also the reset
//                 instruction.
//     undefined - IDCODE opcode decodes to BYPASS, which is also the reset
//                 instruction.
// -----------------------------------------------------------------------------
package jtag_types_pkg;

  localparam int IR_LEN = 4;

  localparam logic [IR_LEN-1:0] OP_EXTEST         = 4'h0;
  localparam logic [IR_LEN-1:0] OP_SAMPLE_PRELOAD = 4'h1;
  localparam logic [IR_LEN-1:0] OP_IDCODE         = 4'h2;
  localparam logic [IR_LEN-1:0] OP_AHB            = 4'h3;
  localparam logic [IR_LEN-1:0] OP_BYPASS         = 4'hF;

  // Fixed capture pattern: the two LSBs "01" let a host check IR continuity.
  localparam logic [IR_LEN-1:0] IR_CAPTURE = 4'b0001;

  typedef enum logic [IR_LEN-1:0] {
    EXTEST         = 4'h0,
    SAMPLE_PRELOAD = 4'h1,
    IDCODE         = 4'h2,
    AHB            = 4'h3,
    BYPASS         = 4'hF
  } instruction_t;

`ifdef JTAG_IDCODE_EN
  localparam instruction_t RESET_INSTR = IDCODE;
`else
  localparam instruction_t RESET_INSTR = BYPASS;
`endif

  // Unknown opcodes fall back to BYPASS so the scan chain always has a
  // defined one-bit path through this device.
  function automatic instruction_t decode_ir(input logic [IR_LEN-1:0] code);
    instruction_t ins;
    ins = BYPASS;
    case (code)
      OP_EXTEST:         ins = EXTEST;
      OP_SAMPLE_PRELOAD: ins = SAMPLE_PRELOAD;
`ifdef JTAG_IDCODE_EN
      OP_IDCODE:         ins = IDCODE;
`endif
      OP_AHB:            ins = AHB;
      default:           ins = BYPASS;
    endcase
    return ins;
  endfunction

endpackage

// File: rtl/jtag_ir.sv
// -----------------------------------------------------------------------------
// jtag_ir
//   JTAG instruction register: the IR shift register plus the active
//   (decoded) instruction latched on update_ir.
//
//   Ports:
//     TCK          in  test clock
//     nTRST        in  asynchronous active-low reset
//     TDI          in  serial data in
//     tlr_reset    in  synchronous reset while TAP is in Test-Logic-Reset
//     capture_ir   in  load IR_CAPTURE into the shift register
//     shift_ir     in  shift TDI in at the MSB
//     update_ir    in  latch decode(ir_sr) into instruction
//     instruction  out active decoded instruction
//     instr_out    out shift register bit 0 (serial out)
//
//   Build option: JTAG_IDCODE_EN (selects reset instruction / decode, see pkg)
// -----------------------------------------------------------------------------
module jtag_ir
  import jtag_types_pkg::*;
(
  input  logic         TCK,
  input  logic         nTRST,
  input  logic         TDI,
  input  logic         tlr_reset,
  input  logic         capture_ir,
  input  logic         shift_ir,
  input  logic         update_ir,
  output instruction_t instruction,
  output logic         instr_out
);

  logic [IR_LEN-1:0] ir_sr;

  // One priority chain: tlr_reset > capture > shift > update. An update
  // that coincides with a capture or shift is dropped, so the active
  // instruction only ever changes from a complete, settled IR scan.
  always_ff @(posedge TCK or negedge nTRST) begin
    if (!nTRST) begin
      ir_sr       <= IR_CAPTURE;
      instruction <= RESET_INSTR;
    end else if (tlr_reset) begin
      ir_sr       <= IR_CAPTURE;
      instruction <= RESET_INSTR;
    end else if (capture_ir) begin
      ir_sr <= IR_CAPTURE;
    end else if (shift_ir) begin
      ir_sr <= {TDI, ir_sr[IR_LEN-1:1]};
    end else if (update_ir) begin
      instruction <= decode_ir(ir_sr);
    end
  end

  assign instr_out = ir_sr[0];

endmodule

// File: rtl/jtag_shift_regs.sv
// -----------------------------------------------------------------------------
// jtag_shift_regs
//   Serial-input side of the JTAG TAP datapath: instruction register (via
//   jtag_ir), bypass register, IDCODE register and the one-hot DR select.
//
//   Parameters:
//     IDCODE_VALUE  device ID captured into the IDCODE register (bit 0 = 1)
//
//   Ports:
//     TCK, nTRST                      clock, async active-low reset
//     TDI                             serial data in
//     tlr_reset                       sync reset in Test-Logic-Reset
//     capture_ir, shift_ir, update_ir IR strobes
//     capture_dr, shift_dr            DR strobes
//     instruction                     active decoded instruction
//     instr_out                       IR shift register bit 0
//     bypass_out                      bypass register
//     idcode_out                      IDCODE shift register bit 0
//     sel_bypass/idcode/bsr/ahb       one-hot DR select
//
//   Build option: JTAG_IDCODE_EN
//     defined   - IDCODE register present, reset instruction is IDCODE.
//     undefined - no IDCODE register, idcode_out and sel_idcode tied 0,
//                 reset instruction is BYPASS.
// -----------------------------------------------------------------------------
module jtag_shift_regs
  import jtag_types_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h1A2B_3C4D
) (
  input  logic         TCK,
  input  logic         nTRST,
  input  logic         TDI,
  input  logic         tlr_reset,
  input  logic         capture_ir,
  input  logic         shift_ir,
  input  logic         update_ir,
  input  logic         capture_dr,
  input  logic         shift_dr,
  output instruction_t instruction,
  output logic         instr_out,
  output logic         bypass_out,
  output logic         idcode_out,
  output logic         sel_bypass,
  output logic         sel_idcode,
  output logic         sel_bsr,
  output logic         sel_ahb
);

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  jtag_ir u_ir (
    .TCK         (TCK),
    .nTRST       (nTRST),
    .TDI         (TDI),
    .tlr_reset   (tlr_reset),
    .capture_ir  (capture_ir),
    .shift_ir    (shift_ir),
    .update_ir   (update_ir),
    .instruction (instruction),
    .instr_out   (instr_out)
  );

  // ---------------------------------------------------------------------------
  // DR select: combinational, exactly one bit high for every instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_bypass = 1'b0;
    sel_idcode = 1'b0;
    sel_bsr    = 1'b0;
    sel_ahb    = 1'b0;
    case (instruction)
      EXTEST, SAMPLE_PRELOAD: sel_bsr = 1'b1;
      AHB:                    sel_ahb = 1'b1;
`ifdef JTAG_IDCODE_EN
      IDCODE:                 sel_idcode = 1'b1;
`else
      IDCODE:                 sel_bypass = 1'b1;
`endif
      default:                sel_bypass = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bypass register: only moves while selected, capture wins over shift
  // ---------------------------------------------------------------------------
  logic bypass_q;

  always_ff @(posedge TCK or negedge nTRST) begin
    if (!nTRST) begin
      bypass_q <= 1'b0;
    end else if (tlr_reset) begin
      bypass_q <= 1'b0;
    end else if (sel_bypass) begin
      if (capture_dr) begin
        bypass_q <= 1'b0;
      end else if (shift_dr) begin
        bypass_q <= TDI;
      end
    end
  end

  assign bypass_out = bypass_q;

  // ---------------------------------------------------------------------------
  // IDCODE register
  // ---------------------------------------------------------------------------
`ifdef JTAG_IDCODE_EN
  logic [31:0] id_sr;

  always_ff @(posedge TCK or negedge nTRST) begin
    if (!nTRST) begin
      id_sr <= IDCODE_VALUE;
    end else if (tlr_reset) begin
      id_sr <= IDCODE_VALUE;
    end else if (sel_idcode) begin
      if (capture_dr) begin
        id_sr <= IDCODE_VALUE;
      end else if (shift_dr) begin
        id_sr <= {TDI, id_sr[31:1]};
      end
    end
  end

  assign idcode_out = id_sr[0];
`else
  // The ID value has no register to load into in this build.
  logic unused_idcode_value;
  assign unused_idcode_value = ^IDCODE_VALUE;
  assign idcode_out          = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_shift_regs.sv
// -----------------------------------------------------------------------------
// tb_jtag_shift_regs
//   Directed self-checking bench for jtag_shift_regs. Expected values are
//   hand-derived constants; the IDCODE-dependent ones follow JTAG_IDCODE_EN.
// -----------------------------------------------------------------------------
module tb_jtag_shift_regs;
  import jtag_types_pkg::*;

  localparam logic [31:0] ID_VAL = 32'h1A2B_3C4D;

`ifdef JTAG_IDCODE_EN
  localparam logic       IDC     = 1'b1;
  localparam logic [3:0] EXP_RST = 4'h2;
  localparam logic [3:0] EXP_OP2 = 4'h2;
`else
  localparam logic       IDC     = 1'b0;
  localparam logic [3:0] EXP_RST = 4'hF;
  localparam logic [3:0] EXP_OP2 = 4'hF;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic TCK = 1'b0;
  logic nTRST, TDI, tlr_reset;
  logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr;
  instruction_t instruction;
  logic instr_out, bypass_out, idcode_out;
  logic sel_bypass, sel_idcode, sel_bsr, sel_ahb;

  always #5 TCK = ~TCK;

  jtag_shift_regs #(.IDCODE_VALUE(ID_VAL)) dut (
    .TCK         (TCK),
    .nTRST       (nTRST),
    .TDI         (TDI),
    .tlr_reset   (tlr_reset),
    .capture_ir  (capture_ir),
    .shift_ir    (shift_ir),
    .update_ir   (update_ir),
    .capture_dr  (capture_dr),
    .shift_dr    (shift_dr),
    .instruction (instruction),
    .instr_out   (instr_out),
    .bypass_out  (bypass_out),
    .idcode_out  (idcode_out),
    .sel_bypass  (sel_bypass),
    .sel_idcode  (sel_idcode),
    .sel_bsr     (sel_bsr),
    .sel_ahb     (sel_ahb)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_ins(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = instruction;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Select vector {bsr, ahb, idcode, bypass}
  task automatic chk_sel(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {sel_bsr, sel_ahb, sel_idcode, sel_bypass};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic clk();
    @(posedge TCK);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] code, input bit do_update);
    capture_ir = 1'b1;
    clk();
    capture_ir = 1'b0;
    shift_ir   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      TDI = code[i];
      clk();
    end
    shift_ir = 1'b0;
    TDI      = 1'b0;
    if (do_update) begin
      update_ir = 1'b1;
      clk();
      update_ir = 1'b0;
    end
  endtask

  localparam logic [3:0] SEL_BYP = 4'b0001;
  localparam logic [3:0] SEL_ID  = 4'b0010;
  localparam logic [3:0] SEL_AHB = 4'b0100;
  localparam logic [3:0] SEL_BSR = 4'b1000;

  logic [3:0]  sel_rst;
  logic [31:0] idv;
  logic [3:0]  pat;

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    sel_rst    = IDC ? SEL_ID : SEL_BYP;
    idv        = ID_VAL;
    pat        = 4'b1011;     // applied LSB-first: 1,1,0,1
    nTRST      = 1'b0;
    TDI        = 1'b0;
    tlr_reset  = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;

    // Reset values while nTRST is held low
    #12;
    chk_ins("rst_instruction", EXP_RST);
    chk_bit("rst_instr_out", instr_out, 1'b1);
    chk_bit("rst_bypass_out", bypass_out, 1'b0);
    chk_bit("rst_idcode_out", idcode_out, IDC);
    chk_sel("rst_sel", sel_rst);
    nTRST = 1'b1;
    clk();
    chk_ins("idle_instruction", EXP_RST);

    // IDCODE readout: capture then 32 shifts of 0
    capture_dr = 1'b1;
    clk();
    capture_dr = 1'b0;
`ifdef JTAG_IDCODE_EN
    chk_bit("id_bit0", idcode_out, idv[0]);
    shift_dr = 1'b1;
    TDI      = 1'b0;
    for (int i = 1; i < 32; i++) begin
      clk();
      chk_bit($sformatf("id_bit%0d", i), idcode_out, idv[i]);
    end
    clk();
    chk_bit("id_drained", idcode_out, 1'b0);
    shift_dr = 1'b0;
`else
    chk_bit("id_absent_capture", idcode_out, 1'b0);
    shift_dr = 1'b1;
    TDI      = 1'b1;
    clk();
    chk_bit("id_absent_shift", idcode_out, 1'b0);
    chk_bit("bypass_default_shift", bypass_out, 1'b1);
    shift_dr = 1'b0;
    TDI      = 1'b0;
`endif

    // IR load BYPASS: instr_out 1, 0, 0, 0, 1
    capture_ir = 1'b1;
    clk();
    capture_ir = 1'b0;
    chk_bit("ir_cap", instr_out, 1'b1);
    shift_ir = 1'b1;
    TDI      = 1'b1;
    clk();
    chk_bit("ir_sh1", instr_out, 1'b0);
    clk();
    chk_bit("ir_sh2", instr_out, 1'b0);
    clk();
    chk_bit("ir_sh3", instr_out, 1'b0);
    chk_ins("ir_shift_keeps_instr", EXP_RST);
    clk();
    chk_bit("ir_sh4", instr_out, 1'b1);
    shift_ir  = 1'b0;
    update_ir = 1'b1;
    clk();
    update_ir = 1'b0;
    chk_ins("upd_bypass", 4'hF);
    chk_sel("upd_bypass_sel", SEL_BYP);

    // Bypass path: 0 after capture, then TDI delayed one cycle
    capture_dr = 1'b1;
    clk();
    capture_dr = 1'b0;
    chk_bit("byp_cap", bypass_out, 1'b0);
    shift_dr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      TDI = pat[i];
      clk();
      chk_bit($sformatf("byp_sh%0d", i), bypass_out, pat[i]);
    end
    shift_dr = 1'b0;
    TDI      = 1'b0;
    chk_bit("id_unselected_hold", idcode_out, 1'b0);

    // Opcode decode, including illegal 4'h7
    load_ir(4'h3, 1'b1);
    chk_ins("dec_ahb", 4'h3);
    chk_sel("dec_ahb_sel", SEL_AHB);
    load_ir(4'h7, 1'b1);
    chk_ins("dec_illegal", 4'hF);
    chk_sel("dec_illegal_sel", SEL_BYP);
    load_ir(4'h2, 1'b1);
    chk_ins("dec_idcode", EXP_OP2);
    chk_sel("dec_idcode_sel", IDC ? SEL_ID : SEL_BYP);
    load_ir(4'h1, 1'b1);
    chk_ins("dec_sample", 4'h1);
    chk_sel("dec_sample_sel", SEL_BSR);
    load_ir(4'h0, 1'b1);
    chk_ins("dec_extest", 4'h0);
    chk_bit("ir_holds_zero", instr_out, 1'b0);

    // tlr_reset for one cycle
    tlr_reset = 1'b1;
    clk();
    tlr_reset = 1'b0;
    chk_ins("tlr_instruction", EXP_RST);
    chk_bit("tlr_instr_out", instr_out, 1'b1);
    chk_sel("tlr_sel", sel_rst);

    // capture_ir beats shift_ir
    shift_ir = 1'b1;
    TDI      = 1'b0;
    clk();
    chk_bit("prio_pre", instr_out, 1'b0);
    capture_ir = 1'b1;
    clk();
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    chk_bit("prio_cap_over_shift", instr_out, 1'b1);

    // IR scan of 4'h3 without update leaves instruction alone
    load_ir(4'h3, 1'b0);
    clk();
    clk();
    chk_ins("scan_no_update", EXP_RST);

    // Set bypass to 1, then switch to AHB: DR strobes must not touch bypass
    load_ir(4'hF, 1'b1);
    shift_dr = 1'b1;
    TDI      = 1'b1;
    clk();
    shift_dr = 1'b0;
    TDI      = 1'b0;
    chk_bit("byp_set", bypass_out, 1'b1);
    load_ir(4'h3, 1'b1);
    capture_dr = 1'b1;
    clk();
    capture_dr = 1'b0;
    chk_bit("byp_unselected_hold", bypass_out, 1'b1);

    // nTRST mid-scan, asserted between clock edges
    capture_ir = 1'b1;
    clk();
    capture_ir = 1'b0;
    shift_ir   = 1'b1;
    TDI        = 1'b0;
    clk();
    clk();
    chk_bit("abort_pre", instr_out, 1'b0);
    #2;
    nTRST = 1'b0;
    #1;
    chk_ins("abort_instruction", EXP_RST);
    chk_bit("abort_instr_out", instr_out, 1'b1);
    chk_bit("abort_bypass_out", bypass_out, 1'b0);
    chk_bit("abort_idcode_out", idcode_out, IDC);
    chk_sel("abort_sel", sel_rst);
    shift_ir = 1'b0;
    #2;
    nTRST = 1'b1;
    clk();
    chk_ins("post_abort_instruction", EXP_RST);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_shift_regs.md
# jtag_shift_regs

Serial-input side of the JTAG TAP datapath: owns the instruction register, bypass register and IDCODE register, shifting TDI into whichever is selected by the TAP controller's capture/shift/update strobes. Its serial LSBs (`instr_out`, `bypass_out`, `idcode_out`) and decoded `instruction` feed the TDO output logic. It sits between the TAP state machine and the TDO mux, alongside the boundary-scan and AHB data registers.

## Interface
Parameters:
- `IDCODE_VALUE`, 32'h1A2B_3C4D: device ID; bit 0 must be 1.

Ports:
- `TCK` in 1: test clock; the only clock.
- `nTRST` in 1: asynchronous, active-low reset.
- `TDI` in 1: serial test data in.
- `tlr_reset` in 1: synchronous reset, asserted while the TAP is in Test-Logic-Reset.
- `capture_ir`, `shift_ir`, `update_ir` in 1 each: IR strobes from the TAP.
- `capture_dr`, `shift_dr` in 1 each: DR strobes from the TAP.
- `instruction` out `instruction_t`: active decoded instruction.
- `instr_out` out 1: IR shift register bit 0.
- `bypass_out` out 1: bypass register.
- `idcode_out` out 1: IDCODE shift register bit 0.
- `sel_bypass`, `sel_idcode`, `sel_bsr`, `sel_ahb` out 1 each: one-hot DR select, combinational from `instruction`.

## Operation
- Opcodes (`IR_LEN` = 4): EXTEST 4'h0, SAMPLE_PRELOAD 4'h1, IDCODE 4'h2, AHB 4'h3, BYPASS 4'hF. All other codes decode to BYPASS.
- Strobe priority when more than one is asserted: `tlr_reset` > capture > shift > update.
- IR shift register `ir_sr`:
  - `capture_ir`: load 4'b0001.
  - `shift_ir`: load {TDI, ir_sr[3:1]}.
- Instruction update: `update_ir` sets `instruction <= decode(ir_sr)`.
- `tlr_reset`: sets `instruction` to IDCODE and `ir_sr` to 4'b0001.
- Bypass register, only when `sel_bypass`:
  - `capture_dr` loads 0.
  - `shift_dr` loads TDI.
- IDCODE register `id_sr[31:0]`, only when `sel_idcode`:
  - `capture_dr` loads `IDCODE_VALUE`.
  - `shift_dr` loads {TDI, id_sr[31:1]}.
- DR strobes for an unselected register leave it unchanged.
- Selects:
  - `sel_bsr` for EXTEST or SAMPLE_PRELOAD.
  - `sel_ahb` for AHB.
  - `sel_idcode` for IDCODE.
  - `sel_bypass` otherwise.
  - Exactly one is high at all times.

## Timing
- All registers update on the TCK rising edge.
- Reset values (`nTRST` low, asynchronous):
  - `instruction` = IDCODE, so `sel_idcode` = 1 and the other selects are 0.
  - `ir_sr` = 4'b0001, so `instr_out` = 1.
  - `bypass_out` = 0.
  - `id_sr` = `IDCODE_VALUE`, so `idcode_out` = 1.
- Serial outputs are direct register bits: the value is valid the cycle after the capture/shift edge. The first shifted-out bit is the captured LSB.
- The new `instruction` and selects are visible the cycle after `update_ir`. The IR is 4-cycle latency TDI→`instr_out`.
- `nTRST` asserted mid-shift aborts immediately: registers return to reset values, with no partial update of `instruction`.
- `shift_ir` never alters `instruction`. An IR scan without `update_ir` leaves the active instruction unchanged.

## Configuration
- `JTAG_IDCODE_EN` defined: IDCODE register and opcode present as described.
- `JTAG_IDCODE_EN` undefined:
  - No `id_sr`; `idcode_out` is tied 0 and `sel_idcode` is tied 0.
  - Opcode 4'h2 decodes to BYPASS.
  - The reset/`tlr_reset` instruction is BYPASS, so `sel_bypass` = 1 out of reset.

## Structure
- `jtag_types_pkg` holds:
  - `IR_LEN`.
  - The `instruction_t` enum (EXTEST, SAMPLE_PRELOAD, IDCODE, AHB, BYPASS).
  - The opcode constants.
  - `IR_CAPTURE` = 4'b0001.
  - A `decode_ir` function.
- One sub-module, `jtag_ir`, holds `ir_sr` plus the instruction update/decode and drives `instruction`/`instr_out`. Bypass, IDCODE and select logic stay in the top.

## Test plan
- Reset: pulse `nTRST` low mid-cycle → `instruction`=IDCODE, `instr_out`=1, `bypass_out`=0, `sel_idcode`=1, asynchronously with no TCK edge.
- IDCODE readout: `capture_dr`, then 32 × `shift_dr` with TDI=0 → `idcode_out` emits 32'h1A2B_3C4D LSB-first (1,0,1,1,0,0,1,0,…).
- IR load BYPASS: `capture_ir`, then shift TDI=1 ×4, then `update_ir` →
  - `instr_out` sequence 1,0,0,0 then 1s.
  - `instruction`=BYPASS and `sel_bypass`=1 the next cycle.
- Bypass path: with BYPASS active, `capture_dr` then shift TDI pattern 1,1,0,1 → `bypass_out` = 0 then 1,1,0,1 delayed one cycle.
- Illegal opcode 4'h7 loaded and updated → `instruction`=BYPASS. `tlr_reset` one cycle → `instruction`=IDCODE.
- Priority and aborts:
  - `capture_ir` and `shift_ir` asserted together → `ir_sr`=4'b0001.
  - IR scan of 4'h3 without `update_ir` → `instruction` unchanged.
  - `nTRST` during scan → reset values.
